// File: rtl/oen_arb_pkg.sv
// Shared types and constants for the output-enable bus arbiter.
package oen_arb_pkg;

  localparam int N_REQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/oen_bus_arbiter_rr_pick.sv
// Combinational round-robin winner search starting just after the last owner.
module rr_pick
  import oen_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       last,
  output logic [1:0]       win,
  output logic             any
);

  logic [1:0] cand;

  // Walk from lowest to highest priority so the highest-priority hit lands last.
  always_comb begin
    win  = last;
    any  = 1'b0;
    cand = last;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = last + k[1:0];
      if (req[cand]) begin
        win = cand;
        any = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/oen_bus_arbiter.sv
// Round-robin owner of a shared bus with a bounded hold time and a one-cycle
// turnaround gap between owners.
module oen_bus_arbiter
  import oen_arb_pkg::*;
#(
  parameter int HOLD = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] Oen,
  output logic [1:0]       gnt_id,
  output logic             gnt_valid,
  output logic             expired
);

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_t           state, state_nx;
  logic [3:0]       cnt, cnt_nx;
  logic [1:0]       last, last_nx;
  logic [N_REQ-1:0] oen_nx;
  logic [1:0]       id_nx;
  logic             exp_nx;
  logic [1:0]       win;
  logic             any;

  rr_pick u_pick (
    .req  (req),
    .last (last),
    .win  (win),
    .any  (any)
  );

  // Next-state and next-output decision; TURN arbitrates exactly like IDLE.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    last_nx  = last;
    oen_nx   = Oen;
    id_nx    = gnt_id;
    exp_nx   = 1'b0;
    case (state)
      IDLE, TURN: begin
        oen_nx = 4'b0000;
        cnt_nx = 4'd0;
        if (any) begin
          state_nx = GRANT;
          oen_nx   = onehot(win);
          id_nx    = win;
          last_nx  = win;
        end else begin
          state_nx = IDLE;
        end
      end
      GRANT: begin
        // Voluntary release wins over the hold limit when both happen together.
        if (!req[gnt_id]) begin
          state_nx = TURN;
          oen_nx   = 4'b0000;
          cnt_nx   = 4'd0;
        end else if (cnt == HOLD_LAST) begin
          state_nx = TURN;
          oen_nx   = 4'b0000;
          cnt_nx   = 4'd0;
          exp_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        oen_nx   = 4'b0000;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  // State and registered outputs; last resets to 3 so req[0] goes first.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      last      <= 2'd3;
      Oen       <= 4'b0000;
      gnt_id    <= 2'd0;
      gnt_valid <= 1'b0;
      expired   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      last      <= last_nx;
      Oen       <= oen_nx;
      gnt_id    <= id_nx;
      gnt_valid <= |oen_nx;
      expired   <= exp_nx;
    end
  end

endmodule
